// File: rtl/axi_write_adapter_pkg.sv
// ---------------------------------------------------------------------------
// axi_write_adapter_pkg
//   Shared definitions for the MEM-stage AXI3 write adapter and its address
//   map helper: FSM state encoding, reset polarity, handshake levels, the
//   constant AXI attribute fields and the kernel-segment window test.
// ---------------------------------------------------------------------------
package axi_write_adapter_pkg;

    // Write FSM states; the encoding is visible on axi_write_state for debug.
    typedef enum logic [1:0] {
        WRITE_FREE   = 2'b00,   // idle, a new store may be captured
        WRITE_BUSY   = 2'b01,   // AW and/or W still pending
        WRITE_WAIT_B = 2'b10    // both channels done, waiting for B
    } write_state_t;

    // Reset is asserted low.
    localparam logic RST_ENABLE = 1'b0;

    // Handshake levels.
    localparam logic VALID     = 1'b1;
    localparam logic INVALID   = 1'b0;
    localparam logic READY     = 1'b1;
    localparam logic NOT_READY = 1'b0;

    // Write response code for a successful write.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Constant attributes of every write: one beat, 4 bytes, privileged data.
    localparam logic [3:0] AXI_LEN_SINGLE  = 4'b0000;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_PRIV   = 3'b001;

    // True when the top three address bits select kseg0 (100) or kseg1 (101),
    // the unmapped windows that alias physical memory from address 0.
    function automatic logic is_kseg01(input logic [2:0] top_bits);
        return (top_bits == 3'b100) || (top_bits == 3'b101);
    endfunction

endpackage

// File: rtl/axi_addr_map.sv
// ---------------------------------------------------------------------------
// axi_addr_map
//   Combinational virtual-to-physical unmap for the kernel segments, shared
//   by the read and write adapters.  Addresses in kseg0/kseg1 have their top
//   three bits cleared; every other address passes through unchanged.
//
// Ports
//   vaddr  in   ADDR_WIDTH  virtual address from the pipeline
//   paddr  out  ADDR_WIDTH  physical address for the AXI address channel
// ---------------------------------------------------------------------------
module axi_addr_map #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] vaddr,
    output logic [ADDR_WIDTH-1:0] paddr
);
    import axi_write_adapter_pkg::*;

    always_comb begin
        paddr = vaddr;
        if (is_kseg01(vaddr[ADDR_WIDTH-1 -: 3])) begin
            paddr[ADDR_WIDTH-1 -: 3] = 3'b000;
        end
    end

endmodule

// File: rtl/axi_write_adapter.sv
// ---------------------------------------------------------------------------
// axi_write_adapter
//   AXI3 write master for the MEM stage: one single-beat, 32-bit, byte-strobed
//   store in flight at a time.  A store is captured from MEM while idle, the
//   AW and W channels are presented together and retire independently, then
//   the B response is accepted and reported back to MEM as a done/err pulse.
//   write_busy lets the read adapter hold off reads that could overtake a
//   pending store.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   aw*  (out) / awready (in)  write address channel; IDs 0, fixed attributes
//   w*   (out) / wready  (in)  write data channel; single beat, wlast = 1
//   bid, bresp, bvalid (in)    write response; bid ignored (one outstanding)
//   bready (out)               high only while waiting for the response
//   mem_we/addr/data/sel (in)  store request from MEM (level)
//   mem_write_accept (out)     1-cycle pulse: store captured
//   mem_write_done   (out)     1-cycle pulse: B response accepted
//   mem_write_err    (out)     with done: response was not OKAY
//   write_busy       (out)     a store is in flight
//   axi_write_state  (out)     FSM state for debug
// ---------------------------------------------------------------------------
module axi_write_adapter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    // Write address channel
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,

    // Write data channel
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    // Write response channel
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,

    // MEM stage interface
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic                    mem_write_accept,
    output logic                    mem_write_done,
    output logic                    mem_write_err,
    output logic                    write_busy,
    output logic [1:0]              axi_write_state
);
    import axi_write_adapter_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    write_state_t          state_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic                  bready_reg;
    logic                  accept_reg;
    logic                  done_reg;
    logic                  err_reg;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] mapped_addr;
    logic                  capture;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  b_fire;
    logic                  aw_done_now;
    logic                  w_done_now;

    // One outstanding write, so the response ID carries no information.
    logic                  unused_bid;
    assign unused_bid = ^bid;

    axi_addr_map #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_map (
        .vaddr (mem_addr),
        .paddr (mapped_addr)
    );

    // A store is only taken while idle; mem_we held through a busy period is
    // simply ignored until the FSM is back in WRITE_FREE.
    assign capture = (state_reg == WRITE_FREE) && mem_we;

    assign aw_fire = awvalid_reg && awready;
    assign w_fire  = wvalid_reg  && wready;
    assign b_fire  = bvalid      && bready_reg;

    // Channel completion including a handshake happening on this edge, so
    // that AW and W finishing together moves straight to WRITE_WAIT_B.
    assign aw_done_now = aw_done_reg || aw_fire;
    assign w_done_now  = w_done_reg  || w_fire;

    // -----------------------------------------------------------------------
    // FSM and AXI-side registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ENABLE) begin
            state_reg   <= WRITE_FREE;
            awaddr_reg  <= '0;
            awvalid_reg <= INVALID;
            wvalid_reg  <= INVALID;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            bready_reg  <= NOT_READY;
        end else begin
            case (state_reg)
                WRITE_FREE: begin
                    if (capture) begin
                        awaddr_reg  <= mapped_addr;
                        awvalid_reg <= VALID;
                        wvalid_reg  <= VALID;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        state_reg   <= WRITE_BUSY;
                    end
                end

                WRITE_BUSY: begin
                    // Valids drop only on their own handshake, so address
                    // and data stay stable for as long as they are offered.
                    if (aw_fire) begin
                        awvalid_reg <= INVALID;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_reg <= INVALID;
                        w_done_reg <= 1'b1;
                    end
                    // bready is raised only now, so a response arriving
                    // before both channels retire is left waiting.
                    if (aw_done_now && w_done_now) begin
                        bready_reg <= READY;
                        state_reg  <= WRITE_WAIT_B;
                    end
                end

                WRITE_WAIT_B: begin
                    if (b_fire) begin
                        bready_reg <= NOT_READY;
                        state_reg  <= WRITE_FREE;
                    end
                end

                default: begin
                    state_reg <= WRITE_FREE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Data and strobe capture, one register slice per byte lane
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
        logic [7:0] data_reg;
        logic       strb_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (reset == RST_ENABLE) begin
                data_reg <= '0;
                strb_reg <= 1'b0;
            end else if (capture) begin
                data_reg <= mem_data[gi*8 +: 8];
                strb_reg <= mem_sel[gi];
            end
        end

        assign wdata[gi*8 +: 8] = data_reg;
        assign wstrb[gi]        = strb_reg;
    end

    // -----------------------------------------------------------------------
    // MEM-side pulses: each lasts exactly the cycle after its edge
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ENABLE) begin
            accept_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            accept_reg <= capture;
            done_reg   <= (state_reg == WRITE_WAIT_B) && b_fire;
            err_reg    <= (state_reg == WRITE_WAIT_B) && b_fire && (bresp != RESP_OKAY);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign awid    = '0;
    assign awaddr  = awaddr_reg;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_FIXED;
    assign awlock  = AXI_LOCK_NORMAL;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_PRIV;
    assign awvalid = awvalid_reg;

    assign wid     = '0;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_reg;

    assign bready  = bready_reg;

    assign mem_write_accept = accept_reg;
    assign mem_write_done   = done_reg;
    assign mem_write_err    = err_reg;
    assign write_busy       = (state_reg != WRITE_FREE);
    assign axi_write_state  = state_reg;

endmodule

// File: tb/tb_axi_write_adapter.sv
module tb_axi_write_adapter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_sel;
    logic        mem_write_accept;
    logic        mem_write_done;
    logic        mem_write_err;
    logic        write_busy;
    logic [1:0]  axi_write_state;

    axi_write_adapter dut (
        .clk              (clk),
        .reset            (reset),
        .awid             (awid),
        .awaddr           (awaddr),
        .awlen            (awlen),
        .awsize           (awsize),
        .awburst          (awburst),
        .awlock           (awlock),
        .awcache          (awcache),
        .awprot           (awprot),
        .awvalid          (awvalid),
        .awready          (awready),
        .wid              (wid),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .wlast            (wlast),
        .wvalid           (wvalid),
        .wready           (wready),
        .bid              (bid),
        .bresp            (bresp),
        .bvalid           (bvalid),
        .bready           (bready),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_sel          (mem_sel),
        .mem_write_accept (mem_write_accept),
        .mem_write_done   (mem_write_done),
        .mem_write_err    (mem_write_err),
        .write_busy       (write_busy),
        .axi_write_state  (axi_write_state)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [1:0]  bresp;
        logic [31:0] exp_awaddr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    // Transaction-level reference model for the random phase.
    bit          m_active, m_aw, m_w, m_acc, m_done, m_err;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_sel;

    logic [5:0]  t4_acc, t4_busy, t4_done, t4_awv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // The kseg0/kseg1 window 0x8000_0000..0xBFFF_FFFF folds onto 0..0x1FFF_FFFF.
    function automatic logic [31:0] map_addr(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    task automatic model_step();
        m_acc  = 0;
        m_done = 0;
        m_err  = 0;
        if (!m_active) begin
            if (mem_we) begin
                m_active = 1; m_aw = 1; m_w = 1; m_acc = 1;
                m_addr = map_addr(mem_addr); m_data = mem_data; m_sel = mem_sel;
            end
        end else if (m_aw || m_w) begin
            if (awready) m_aw = 0;
            if (wready)  m_w  = 0;
        end else if (bvalid) begin
            m_active = 0; m_done = 1; m_err = (bresp != 2'b00);
        end
    endtask

    // Accept the pending response and check the done/err pulse is one cycle.
    task automatic finish_b(input string tag, input logic [1:0] resp, input logic exp_err);
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        chk({tag, ".done"},  mem_write_done, 1);
        chk({tag, ".err"},   mem_write_err, exp_err);
        chk({tag, ".state"}, axi_write_state, 0);
        chk({tag, ".busy"},  {write_busy, bready}, 0);
        bvalid = 1'b0;
        tick();
        chk({tag, ".pulse_end"}, {mem_write_done, mem_write_err}, 0);
    endtask

    // Full store with immediate AW/W readiness, starting and ending idle.
    task automatic run_txn(input string tag, input vec_t v);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        mem_we = 1'b1; mem_addr = v.addr; mem_data = v.data; mem_sel = v.sel;
        tick();
        chk({tag, ".accept"}, mem_write_accept, 1);
        chk({tag, ".valids"}, {awvalid, wvalid, bready}, 3'b110);
        chk({tag, ".awaddr"}, awaddr, v.exp_awaddr);
        chk({tag, ".wdata"},  wdata, v.data);
        chk({tag, ".wstrb"},  wstrb, v.sel);
        chk({tag, ".busy"},   {write_busy, axi_write_state}, 3'b101);
        mem_we = 1'b0;
        tick();
        chk({tag, ".waitb"},  {awvalid, wvalid, bready, mem_write_accept}, 4'b0010);
        chk({tag, ".state2"}, axi_write_state, 2);
        finish_b(tag, v.bresp, v.exp_err);
        $display("txn %s addr=%08h awaddr=%08h data=%08h strb=%h err=%0d",
                 tag, v.addr, awaddr, wdata, wstrb, v.exp_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, {awvalid, wvalid, bready, write_busy,
                            mem_write_accept, mem_write_done, mem_write_err}, 0);
        chk({tag, ".awaddr"}, awaddr, 0);
        chk({tag, ".wdata"},  wdata, 0);
        chk({tag, ".wstrb"},  wstrb, 0);
        chk({tag, ".state"},  axi_write_state, 0);
        chk({tag, ".const"}, {awid, awlen, awsize, awburst, awlock, awcache, awprot, wid, wlast},
            {4'h0, 4'h0, 3'b010, 2'b00, 2'b00, 4'h0, 3'b001, 4'h0, 1'b1});
    endtask

    initial begin
        int dones;
        reset = 1'b0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        mem_we = 0; mem_addr = 0; mem_data = 0; mem_sel = 0;
        m_active = 0; m_aw = 0; m_w = 0; m_acc = 0; m_done = 0; m_err = 0;
        m_addr = 0; m_data = 0; m_sel = 0;

        vecs[0] = '{32'hBFC0_0010, 32'h1234_5678, 4'hF, 2'b00, 32'h1FC0_0010, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'hDEAD_BEEF, 4'h1, 2'b00, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'hA000_1234, 32'hCAFE_F00D, 4'h6, 2'b10, 32'h0000_1234, 1'b1};
        vecs[3] = '{32'h0000_0040, 32'h0BAD_C0DE, 4'h0, 2'b00, 32'h0000_0040, 1'b0};
        vecs[4] = '{32'hC000_0000, 32'h1111_2222, 4'h8, 2'b11, 32'hC000_0000, 1'b1};
        vecs[5] = '{32'h7FFF_FFFC, 32'h55AA_55AA, 4'hC, 2'b01, 32'h7FFF_FFFC, 1'b1};
        vecs[6] = '{32'h9FFF_FFFF, 32'h0000_0000, 4'h3, 2'b00, 32'h1FFF_FFFF, 1'b0};
        vecs[7] = '{32'h6000_0000, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h6000_0000, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Table: mapping, strobes (including 0), OKAY and error responses
        for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // AW late by three cycles, W immediate
        awready = 0; wready = 1; mem_we = 1;
        mem_addr = 32'hBFC0_0100; mem_data = 32'hA5A5_0001; mem_sel = 4'hF;
        tick();
        chk("t2.accept", mem_write_accept, 1);
        chk("t2.valids", {awvalid, wvalid}, 2'b11);
        mem_we = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t2.aw_held", {awvalid, wvalid, bready}, 3'b100);
            chk("t2.awaddr",  awaddr, 32'h1FC0_0100);
            chk("t2.state",   axi_write_state, 1);
        end
        awready = 1;
        tick();
        chk("t2.waitb", {awvalid, bready, axi_write_state}, 4'b0110);
        finish_b("t2", 2'b00, 1'b0);
        $display("txn t2 late AW done");

        // mem_we held high across two stores
        t4_acc = 6'b001001; t4_busy = 6'b011011; t4_done = 6'b100100; t4_awv = 6'b001001;
        awready = 1; wready = 1; bvalid = 1; bresp = 0;
        mem_we = 1; mem_addr = 32'h8000_0000; mem_data = 32'h0000_00AA; mem_sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4.acc%0d", i),  mem_write_accept, t4_acc[i]);
            chk($sformatf("t4.busy%0d", i), write_busy, t4_busy[i]);
            chk($sformatf("t4.done%0d", i), mem_write_done, t4_done[i]);
            chk($sformatf("t4.awv%0d", i),  awvalid, t4_awv[i]);
            if (i == 0) begin
                chk("t4.addr1", awaddr, 32'h0000_0000);
                mem_addr = 32'h0000_0040; mem_data = 32'h0000_00BB;
            end
            if (i == 3) begin
                chk("t4.addr2", awaddr, 32'h0000_0040);
                chk("t4.data2", wdata, 32'h0000_00BB);
                mem_we = 0;
            end
        end
        bvalid = 0;
        tick();
        $display("txn t4 two held-request stores done");

        // Early bvalid while W still pending
        awready = 1; wready = 0; bvalid = 1; bresp = 0;
        mem_we = 1; mem_addr = 32'h0000_1000; mem_data = 32'h600D_600D; mem_sel = 4'hF;
        tick();
        chk("t6.accept", mem_write_accept, 1);
        mem_we = 0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.bready_hold", {bready, wvalid, mem_write_done}, 3'b010);
        end
        wready = 1;
        tick();
        dones += int'(mem_write_done);
        chk("t6.waitb", {bready, wvalid}, 2'b10);
        tick();
        dones += int'(mem_write_done);
        chk("t6.done", mem_write_done, 1);
        bvalid = 0;
        tick();
        dones += int'(mem_write_done);
        tick();
        dones += int'(mem_write_done);
        chk("t6.done_count", dones, 1);
        $display("txn t6 early bvalid done");

        // Asynchronous reset in WAIT_B
        awready = 1; wready = 1; bvalid = 0;
        mem_we = 1; mem_addr = 32'hA000_0080; mem_data = 32'h1357_9BDF; mem_sel = 4'h5;
        tick();
        mem_we = 0;
        tick();
        chk("t5.in_waitb", axi_write_state, 2);
        reset = 1'b0;
        #1;
        chk_all_zero("t5.rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_txn("t5.after", vecs[2]);

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            mem_we   = ($urandom_range(0, 2) == 0);
            mem_addr = $urandom;
            mem_data = $urandom;
            mem_sel  = 4'($urandom_range(0, 15));
            awready  = 1'($urandom_range(0, 1));
            wready   = 1'($urandom_range(0, 1));
            bvalid   = 1'($urandom_range(0, 1));
            bresp    = 2'($urandom_range(0, 3));
            model_step();
            tick();
            chk("rnd.ctl",
                {awvalid, wvalid, bready, write_busy, mem_write_accept, mem_write_done, mem_write_err},
                {m_active & m_aw, m_active & m_w, m_active & !m_aw & !m_w, m_active, m_acc, m_done, m_err});
            if (m_active) begin
                chk("rnd.awaddr", awaddr, m_addr);
                chk("rnd.wdata",  wdata, m_data);
                chk("rnd.wstrb",  wstrb, m_sel);
            end
            if (m_done) $display("txn rnd cycle %0d done err=%0d", c, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
